window_slide_sched: RTL and testbench
=====================================

// Module: window_slide_sched
// PURPOSE
//  Sequencer/arbiter around the window-slide engine. Owns the single-port image RAM:
//  - host loads the image while idle; the engine reads it during a run.
//  - issues engine start/slide, captures each KxK window with its (row,col) tag.
//  - presents windows downstream on a valid/ready handshake; flags stalls and aborts.
// PARAMETERS
//  DATA_WIDTH      8    RAM word width
//  DATA_ADDR_WIDTH 10   RAM address width
//  IMAGE_ROW_LEN   32   image rows
//  IMAGE_COL_LEN   32   image columns
//  KERNEL_SIZE     3    window edge K; window is K*K bits
//  STRIDE          1    slide step; OUT_ROWS=(IMAGE_ROW_LEN-K)/STRIDE+1, OUT_COLS likewise
//  TIMEOUT         1024 max cycles from ws_slide/ws_start to ws_valid before error
// PORTS
//  clk           in  1              system clock
//  rst           in  1              reset: asynchronous, active-low
//  cfg_start     in  1              pulse: process one image
//  cfg_abort     in  1              pulse: abandon current run
//  cfg_busy      out 1              high from start accept until return to IDLE
//  cfg_done      out 1              1-cycle pulse after last window accepted
//  cfg_err       out 1              sticky timeout/early-done flag, cleared by accepted cfg_start
//  host_wr_en    in  1              host write request
//  host_wr_addr  in  DATA_ADDR_WIDTH  host write address
//  host_wr_data  in  DATA_WIDTH     host write data
//  host_wr_ready out 1              host write accepted this cycle (IDLE only)
//  ram_addr      out DATA_ADDR_WIDTH  muxed RAM address
//  ram_wdata     out DATA_WIDTH     RAM write data
//  ram_wen       out 1              RAM write enable
//  ram_ren       out 1              RAM read enable
//  ws_start      out 1              engine start pulse
//  ws_slide      out 1              engine slide pulse
//  ws_ram_addr   in  DATA_ADDR_WIDTH  engine read address
//  ws_ram_ren    in  1              engine read request
//  ws_window     in  K*K            engine window bits
//  ws_valid      in  1              engine window valid (level, sampled on clk)
//  ws_done       in  1              engine finished image
//  win_data      out K*K            captured window
//  win_row       out $clog2(OUT_ROWS)  window row index
//  win_col       out $clog2(OUT_COLS)  window column index
//  win_last      out 1              final window of image
//  win_valid     out 1              window available
//  win_ready     in  1              downstream accepts when valid&ready
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0; host_wr_ready=1 only via IDLE decode (0 while rst low).
//  - RAM mux: IDLE -> host drives (ram_wen=host_wr_en, host_wr_ready=1).
//    Otherwise engine drives (ram_addr=ws_ram_addr, ram_ren=ws_ram_ren, ram_wen=0, host_wr_ready=0).
//  - Start+write in the same IDLE cycle: the write completes, start is accepted, and LAUNCH
//    follows next cycle. cfg_start outside IDLE is ignored.
//  - FSM:
//    IDLE -start-> LAUNCH (ws_start=1 for 1 cycle; clear cfg_err, row=col=0)
//    LAUNCH -> WAIT_WIN
//    WAIT_WIN: on ws_valid=1 capture ws_window, win_valid<=1 -> HOLD
//    HOLD: on win_valid&win_ready: if win_last -> DONE, else advance row/col -> SLIDE
//    SLIDE: ws_slide=1 for 1 cycle -> WAIT_WIN (ws_valid ignored during SLIDE and its cycle)
//    DONE: cfg_done=1 for 1 cycle -> IDLE
//  - Latency: window appears on win_* one cycle after ws_valid is sampled high.
//    At most one window is in flight; there is no slide until the previous window is accepted.
//  - win_* outputs are stable while win_valid=1 and win_ready=0.
//  - Counters: col 0..OUT_COLS-1, then wrap to 0 with row+1. win_last=(row==OUT_ROWS-1)&&(col==OUT_COLS-1).
//  - Timeout: a wait counter runs in WAIT_WIN and resets on entry. Reaching TIMEOUT -> cfg_err=1, go IDLE.
//  - ws_done high before the last window is accepted -> cfg_err=1, go IDLE.
//  - cfg_abort in any non-IDLE state -> IDLE next cycle: win_valid=0, no cfg_done, cfg_err unchanged.
//    Abort has priority over a simultaneous handshake.
//  - cfg_busy=1 in every state except IDLE.
// STRUCTURE
//  - window_pkg: ws_sched_state_t enum, out_dim(len,k,stride) function, window width const.
//  - Sub-module window_pos_counter: row/col counter with advance, clear and last outputs.
// TESTING
//  - Load 1024 words while idle, then read back via the engine model.
//    -> host_wr_ready=1 throughout, RAM contents match.
//  - 4x4 image, K=3, STRIDE=1, win_ready tied 1.
//    -> windows (0,0),(0,1),(1,0),(1,1); win_last on 4th; cfg_done 1 cycle later.
//  - Downstream backpressure: win_ready low 5 cycles on window (0,1).
//    -> win_data/row/col held stable, no ws_slide issued until accept.
//  - Engine model withholds ws_valid, TIMEOUT=16.
//    -> cfg_err=1 after 16 cycles in WAIT_WIN, FSM IDLE, cfg_err clears on next start.
//  - cfg_abort during HOLD with win_ready=1 same cycle.
//    -> no transfer counted, win_valid=0, IDLE, no cfg_done.
//  - rst low mid-run (during SLIDE). -> all outputs 0 immediately; cfg_start then runs a full image cleanly.

Source files
------------

// File: rtl/window_pkg.sv
// Shared state encoding and sizing helpers for the window-slide scheduler.
package window_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_WIN,
        S_HOLD,
        S_SLIDE,
        S_DONE
    } ws_sched_state_t;

    localparam int DEF_KERNEL = 3;

    function automatic int out_dim(input int len, input int k, input int stride);
        return (len - k) / stride + 1;
    endfunction

    function automatic int win_width(input int k);
        return k * k;
    endfunction

    // Index fields stay at least one bit wide even for a single-window axis.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Raster (row, col) position of the window currently held for downstream.
module window_pos_counter #(
    parameter int OUT_ROWS = 30,
    parameter int OUT_COLS = 30,
    parameter int ROW_W    = 5,
    parameter int COL_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_row_end;
    logic             w_col_end;

    assign w_row_end = (r_row == ROW_W'(OUT_ROWS - 1));
    assign w_col_end = (r_col == COL_W'(OUT_COLS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_row_end && w_col_end;

endmodule

// File: rtl/window_slide_sched.sv
// Sequencer around the window-slide engine: owns the image RAM port, paces the
// engine one window at a time and hands tagged windows downstream.
module window_slide_sched
    import window_pkg::*;
#(
    parameter int  DATA_WIDTH      = 8,
    parameter int  DATA_ADDR_WIDTH = 10,
    parameter int  IMAGE_ROW_LEN   = 32,
    parameter int  IMAGE_COL_LEN   = 32,
    parameter int  KERNEL_SIZE     = DEF_KERNEL,
    parameter int  STRIDE          = 1,
    parameter int  TIMEOUT         = 1024,
    localparam int OUT_ROWS = out_dim(IMAGE_ROW_LEN, KERNEL_SIZE, STRIDE),
    localparam int OUT_COLS = out_dim(IMAGE_COL_LEN, KERNEL_SIZE, STRIDE),
    localparam int WIN_W    = win_width(KERNEL_SIZE),
    localparam int ROW_W    = idx_width(OUT_ROWS),
    localparam int COL_W    = idx_width(OUT_COLS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic                       cfg_abort,
    output logic                       cfg_busy,
    output logic                       cfg_done,
    output logic                       cfg_err,
    input  logic                       host_wr_en,
    input  logic [DATA_ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0]      host_wr_data,
    output logic                       host_wr_ready,
    output logic [DATA_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]      ram_wdata,
    output logic                       ram_wen,
    output logic                       ram_ren,
    output logic                       ws_start,
    output logic                       ws_slide,
    input  logic [DATA_ADDR_WIDTH-1:0] ws_ram_addr,
    input  logic                       ws_ram_ren,
    input  logic [WIN_W-1:0]           ws_window,
    input  logic                       ws_valid,
    input  logic                       ws_done,
    output logic [WIN_W-1:0]           win_data,
    output logic [ROW_W-1:0]           win_row,
    output logic [COL_W-1:0]           win_col,
    output logic                       win_last,
    output logic                       win_valid,
    input  logic                       win_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);

    ws_sched_state_t  r_state;
    ws_sched_state_t  w_next;
    logic [TW-1:0]    r_wait;
    logic [WIN_W-1:0] r_win_data;
    logic             r_err;
    logic             w_start_acc;
    logic             w_handshake;
    logic             w_last;
    logic             w_early_done;
    logic             w_timeout;
    logic             w_fault;
    logic             w_capture;
    logic             w_advance;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;

    assign w_start_acc  = (r_state == S_IDLE) && cfg_start;
    assign w_handshake  = (r_state == S_HOLD) && win_ready;
    // Engine finishing in the same cycle the final window is taken is the normal end.
    assign w_early_done = ws_done && (r_state != S_IDLE) && (r_state != S_DONE)
                          && !(w_handshake && w_last);
    assign w_timeout    = (r_state == S_WAIT_WIN) && !ws_valid && (r_wait == TW'(TIMEOUT - 1));
    assign w_fault      = (w_early_done || w_timeout) && !cfg_abort;
    assign w_capture    = (r_state == S_WAIT_WIN) && (w_next == S_HOLD);
    assign w_advance    = w_handshake && !w_last && !cfg_abort && !w_early_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (cfg_start) w_next = S_LAUNCH;
            S_LAUNCH:   w_next = S_WAIT_WIN;
            S_WAIT_WIN: if (ws_valid) w_next = S_HOLD;
            S_HOLD:     if (win_ready) w_next = w_last ? S_DONE : S_SLIDE;
            S_SLIDE:    w_next = S_WAIT_WIN;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        // Abort outranks any handshake or capture in the same cycle.
        if ((r_state != S_IDLE) && (cfg_abort || w_early_done || w_timeout)) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        host_wr_ready = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        ram_wen       = 1'b0;
        ram_ren       = 1'b0;
        cfg_busy      = 1'b0;
        ws_start      = 1'b0;
        ws_slide      = 1'b0;
        cfg_done      = 1'b0;
        win_valid     = 1'b0;
        if (rst) begin
            if (r_state == S_IDLE) begin
                host_wr_ready = 1'b1;
                ram_addr      = host_wr_addr;
                ram_wdata     = host_wr_data;
                ram_wen       = host_wr_en;
            end else begin
                ram_addr = ws_ram_addr;
                ram_ren  = ws_ram_ren;
                cfg_busy = 1'b1;
            end
            ws_start  = (r_state == S_LAUNCH);
            ws_slide  = (r_state == S_SLIDE);
            cfg_done  = (r_state == S_DONE);
            win_valid = (r_state == S_HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait     <= '0;
            r_win_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wait <= (r_state == S_WAIT_WIN) ? r_wait + TW'(1) : '0;
            if (w_capture) begin
                r_win_data <= ws_window;
            end
            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_fault) begin
                r_err <= 1'b1;
            end
        end
    end

    window_pos_counter #(
        .OUT_ROWS (OUT_ROWS),
        .OUT_COLS (OUT_COLS),
        .ROW_W    (ROW_W),
        .COL_W    (COL_W)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_start_acc),
        .i_advance (w_advance),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    assign win_data = r_win_data;
    assign win_row  = w_row;
    assign win_col  = w_col;
    assign win_last = w_last && (r_state == S_HOLD);
    assign cfg_err  = r_err;

endmodule

// File: tb/tb_window_slide_sched.sv
// Bench for window_slide_sched: 4x4 image, 3x3 kernel, short timeout, with a
// behavioural engine and RAM around the scheduler.
module tb_window_slide_sched;

    localparam int DW = 8, AW = 10, ROWS = 4, COLS = 4, K = 3, STR = 1, TMO = 16;
    localparam int O_ROWS = 2, O_COLS = 2, RW = 1, CW = 1, WW = 9, NWIN = 4;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cfg_start = 1'b0, cfg_abort = 1'b0;
    logic cfg_busy, cfg_done, cfg_err;
    logic host_wr_en = 1'b0;
    logic [AW-1:0] host_wr_addr = '0;
    logic [DW-1:0] host_wr_data = '0;
    logic host_wr_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic ram_wen, ram_ren, ws_start, ws_slide;
    logic [AW-1:0] ws_ram_addr = '0;
    logic ws_ram_ren = 1'b0;
    logic [WW-1:0] ws_window;
    logic ws_valid;
    logic ws_done = 1'b0;
    logic [WW-1:0] win_data;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic win_last, win_valid;
    logic win_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    logic [AW+DW+WW+RW+CW+10-1:0] outs;

    int   eng_idx, eng_dly;
    int   eng_run = 0;
    int   eng_lat = 2;
    logic eng_pend;
    logic eng_hold = 1'b0;

    window_slide_sched #(
        .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .IMAGE_ROW_LEN(ROWS), .IMAGE_COL_LEN(COLS),
        .KERNEL_SIZE(K), .STRIDE(STR), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_wr_ready(host_wr_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wen(ram_wen), .ram_ren(ram_ren), .ws_start(ws_start), .ws_slide(ws_slide),
        .ws_ram_addr(ws_ram_addr), .ws_ram_ren(ws_ram_ren), .ws_window(ws_window),
        .ws_valid(ws_valid), .ws_done(ws_done), .win_data(win_data), .win_row(win_row),
        .win_col(win_col), .win_last(win_last), .win_valid(win_valid), .win_ready(win_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int a);
        return DW'((a * 13 + 91) ^ (a >> 2));
    endfunction

    function automatic logic [WW-1:0] win_pat(input int idx, input int run);
        return WW'(idx * 53 + run * 29 + 7);
    endfunction

    function automatic exp_t mk_exp(input int idx, input int run);
        exp_t e;
        e.data = win_pat(idx, run);
        e.row  = RW'(idx / O_COLS);
        e.col  = CW'(idx % O_COLS);
        e.last = (idx == NWIN - 1);
        return e;
    endfunction

    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_wdata;
    end
    assign ram_q = mem[ram_addr];
    assign outs = {cfg_busy, cfg_done, cfg_err, host_wr_ready, ram_addr, ram_wdata, ram_wen,
                   ram_ren, ws_start, ws_slide, win_data, win_row, win_col, win_last, win_valid};

    // Engine model: one window per start/slide, eng_lat cycles later, as a 1-cycle pulse.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ws_valid  <= 1'b0;
            ws_window <= '0;
            eng_pend  <= 1'b0;
            eng_idx   <= 0;
            eng_dly   <= 0;
        end else begin
            ws_valid <= 1'b0;
            if (ws_start) begin
                eng_idx  <= 0;
                eng_pend <= !eng_hold;
                eng_dly  <= eng_lat;
                eng_run  <= eng_run + 1;
            end else if (ws_slide) begin
                eng_idx  <= eng_idx + 1;
                eng_pend <= !eng_hold;
                eng_dly  <= eng_lat;
            end else if (eng_pend) begin
                if (eng_dly == 0) begin
                    ws_valid  <= 1'b1;
                    ws_window <= win_pat(eng_idx, eng_run);
                    eng_pend  <= 1'b0;
                    sb.push_back(mk_exp(eng_idx, eng_run));
                end else begin
                    eng_dly <= eng_dly - 1;
                end
            end
        end
    end

    task automatic run_image(input int stall_win, input int stall_cyc, input string tag);
        exp_t e;
        int   n;
        win_ready = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int k = 0; k < NWIN; k++) begin
            n = 0;
            while (win_valid !== 1'b1 && n < 64) begin
                @(negedge clk);
                n++;
            end
            n_chk++;
            if (win_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_wait%0d: win_valid got %b required 1", tag, k, win_valid);
                return;
            end
            e = '0;
            if (sb.size() > 0) e = sb.pop_front();
            n_chk++;
            if ({win_data, win_row, win_col, win_last} !== e) begin
                n_fail++;
                $display("FAIL %s_win%0d: got %h required %h", tag, k,
                         {win_data, win_row, win_col, win_last}, e);
            end
            if (k == stall_win) begin
                win_ready = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    @(negedge clk);
                    n_chk++;
                    if ({win_valid, ws_slide, win_data, win_row, win_col, win_last} !== {2'b10, e}) begin
                        n_fail++;
                        $display("FAIL %s_hold%0d: got %h required %h", tag, s,
                                 {win_valid, ws_slide, win_data, win_row, win_col, win_last}, {2'b10, e});
                    end
                end
                win_ready = 1'b1;
            end
            @(negedge clk);
            n_chk++;
            if (k < NWIN - 1) begin
                if ({ws_slide, win_valid, cfg_done} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL %s_slide%0d: slide/valid/done got %b required 100", tag, k,
                             {ws_slide, win_valid, cfg_done});
                end
            end else if ({cfg_done, cfg_busy} !== 2'b11) begin
                n_fail++;
                $display("FAIL %s_done: done/busy got %b required 11", tag, {cfg_done, cfg_busy});
            end
        end
        @(negedge clk);
        n_chk++;
        if ({cfg_done, cfg_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_idle: done/busy got %b required 00", tag, {cfg_done, cfg_busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h required 0", outs);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({host_wr_ready, cfg_busy, cfg_err, win_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_idle: ready/busy/err/valid got %b required 1000",
                     {host_wr_ready, cfg_busy, cfg_err, win_valid});
        end
    endtask

    task automatic test_ram_load();
        exp_t e;
        int   n;
        win_ready = 1'b0;
        for (int a = 0; a < (1 << AW); a++) begin
            host_wr_en   = 1'b1;
            host_wr_addr = AW'(a);
            host_wr_data = pat(a);
            cfg_start    = (a == (1 << AW) - 1);
            #1;
            n_chk++;
            if ({host_wr_ready, ram_wen, ram_addr, ram_wdata} !== {2'b11, AW'(a), pat(a)}) begin
                n_fail++;
                $display("FAIL load_%0d: got %h required %h", a,
                         {host_wr_ready, ram_wen, ram_addr, ram_wdata}, {2'b11, AW'(a), pat(a)});
            end
            @(negedge clk);
        end
        n_chk++;
        if ({cfg_busy, host_wr_ready, ram_wen} !== 3'b100) begin
            n_fail++;
            $display("FAIL load_start_accept: busy/ready/wen got %b required 100",
                     {cfg_busy, host_wr_ready, ram_wen});
        end
        host_wr_en = 1'b0;
        cfg_start  = 1'b0;
        n = 0;
        while (win_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        n_chk++;
        if ({win_valid, win_data, win_row, win_col, win_last} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL load_win0: got %h required %h",
                     {win_valid, win_data, win_row, win_col, win_last}, {1'b1, e});
        end
        for (int a = 0; a < (1 << AW); a++) begin
            ws_ram_addr = AW'(a);
            ws_ram_ren  = 1'b1;
            #1;
            n_chk++;
            if ({ram_ren, ram_wen, ram_addr, ram_q} !== {2'b10, AW'(a), pat(a)}) begin
                n_fail++;
                $display("FAIL readback_%0d: got %h required %h", a,
                         {ram_ren, ram_wen, ram_addr, ram_q}, {2'b10, AW'(a), pat(a)});
            end
        end
        ws_ram_ren = 1'b0;
        @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        sb.delete();
        n_chk++;
        if ({cfg_busy, host_wr_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL load_abort: busy/ready got %b required 01", {cfg_busy, host_wr_ready});
        end
    endtask

    task automatic test_basic();
        run_image(-1, 0, "basic");
    endtask

    task automatic test_backpressure();
        run_image(1, 5, "bp");
    endtask

    task automatic test_timeout();
        eng_hold  = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (16) @(negedge clk);
        n_chk++;
        if ({cfg_busy, cfg_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL tmo_before: busy/err got %b required 10", {cfg_busy, cfg_err});
        end
        @(negedge clk);
        n_chk++;
        if ({cfg_busy, cfg_err, host_wr_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL tmo_fire: busy/err/ready got %b required 011", {cfg_busy, cfg_err, host_wr_ready});
        end
        repeat (3) @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        n_chk++;
        if ({cfg_busy, cfg_err, ws_start} !== 3'b101) begin
            n_fail++;
            $display("FAIL tmo_clear: busy/err/start got %b required 101", {cfg_busy, cfg_err, ws_start});
        end
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        eng_hold  = 1'b0;
        sb.delete();
    endtask

    task automatic test_abort();
        exp_t e;
        int   n;
        win_ready = 1'b0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        n = 0;
        while (win_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        n_chk++;
        if ({win_valid, win_data, win_row, win_col} !== {1'b1, e.data, e.row, e.col}) begin
            n_fail++;
            $display("FAIL abort_win0: got %h required %h",
                     {win_valid, win_data, win_row, win_col}, {1'b1, e.data, e.row, e.col});
        end
        cfg_abort = 1'b1;
        win_ready = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        win_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            n_chk++;
            if ({win_valid, cfg_busy, cfg_done, cfg_err, ws_slide} !== 5'b00000) begin
                n_fail++;
                $display("FAIL abort_idle%0d: valid/busy/done/err/slide got %b required 00000", s,
                         {win_valid, cfg_busy, cfg_done, cfg_err, ws_slide});
            end
            @(negedge clk);
        end
        sb.delete();
    endtask

    task automatic test_early_done();
        eng_hold  = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        ws_done = 1'b1;
        @(negedge clk);
        ws_done = 1'b0;
        n_chk++;
        if ({cfg_busy, cfg_err, cfg_done} !== 3'b010) begin
            n_fail++;
            $display("FAIL early_done: busy/err/done got %b required 010", {cfg_busy, cfg_err, cfg_done});
        end
        eng_hold = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset_midrun();
        int n;
        win_ready = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        n = 0;
        while (ws_slide !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (ws_slide !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_slide: ws_slide got %b required 1", ws_slide);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL midrst_outs: got %h required 0", outs);
        end
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        run_image(-1, 0, "post_rst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ram_load();
        test_basic();
        test_backpressure();
        test_timeout();
        test_abort();
        test_early_done();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
